// File: rtl/fused_tx_pkg.sv
// fused_tx_pkg: shared types and constants for the fused tensor transmitter.
//   fused_tx_state_t : serialiser FSM states
//   fused_tx_meta_t  : per-tensor side information (error flags + timestamp)
//   *_DEFAULT        : default widths / sync pattern used by the top
// Optional build macro: FUSED_TX_DOUBLE_BUFFER_EN (see fused_tx_holding_buf).
package fused_tx_pkg;

  localparam int          TENSOR_WIDTH_DEFAULT = 2048;
  localparam int          WORD_WIDTH_DEFAULT   = 32;
  localparam logic [15:0] SYNC_WORD_DEFAULT    = 16'hA5C3;

  localparam int PAYLOAD_WORDS = TENSOR_WIDTH_DEFAULT / WORD_WIDTH_DEFAULT;
  localparam int HDR_WORDS     = 3;                            // HDR, TS_HI, TS_LO
  localparam int FRAME_WORDS   = HDR_WORDS + PAYLOAD_WORDS + 1; // + trailer = 68

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TS_HI,
    ST_TS_LO,
    ST_PAYLOAD,
    ST_TRAILER
  } fused_tx_state_t;

  typedef struct packed {
    logic [7:0]  flags;
    logic [63:0] ts;
  } fused_tx_meta_t;

endpackage

// File: rtl/fused_tensor_tx_if.sv
// fused_tensor_tx_if: tensor input handshake plus framed word stream output.
//   in_*      : tensor, error flags, timestamp, valid/ready from the fusion core
//   tx_*      : 32-bit framed stream with sof/last markers, valid/ready
//   frame_seq : sequence number of the frame held or next to send
// Modports: slave = the transmitter block, master = its surroundings
// (upstream producer and downstream consumer).
interface fused_tensor_tx_if #(
  parameter int TENSOR_WIDTH = 2048,
  parameter int WORD_WIDTH   = 32
);
  logic [TENSOR_WIDTH-1:0] in_tensor;
  logic [7:0]              in_error_flags;
  logic [63:0]             in_timestamp;
  logic                    in_valid;
  logic                    in_ready;
  logic [WORD_WIDTH-1:0]   tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    tx_sof;
  logic                    tx_last;
  logic [7:0]              frame_seq;

  modport slave (
    input  in_tensor, in_error_flags, in_timestamp, in_valid, tx_ready,
    output in_ready, tx_data, tx_valid, tx_sof, tx_last, frame_seq
  );

  modport master (
    output in_tensor, in_error_flags, in_timestamp, in_valid, tx_ready,
    input  in_ready, tx_data, tx_valid, tx_sof, tx_last, frame_seq
  );
endinterface

// File: rtl/fused_tx_holding_buf.sv
// fused_tx_holding_buf: frame register the serialiser reads from, plus an
// optional one-entry pending slot (FUSED_TX_DOUBLE_BUFFER_EN).
//   in_*       : upstream tensor/meta with valid/ready
//   idle       : serialiser is idle, frame register free
//   trl_hs     : trailer handshake this cycle (double-buffer build only)
//   start      : frame register loads a new frame on this edge
//   frm_*      : frame register contents
// Without the macro in_ready follows idle; with it in_ready means the
// pending slot is empty.
module fused_tx_holding_buf
  import fused_tx_pkg::*;
#(
  parameter int TENSOR_WIDTH = TENSOR_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TENSOR_WIDTH-1:0] in_tensor,
  input  fused_tx_meta_t          in_meta,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    idle,
`ifdef FUSED_TX_DOUBLE_BUFFER_EN
  input  logic                    trl_hs,
`endif
  output logic                    start,
  output logic [TENSOR_WIDTH-1:0] frm_tensor,
  output fused_tx_meta_t          frm_meta
);

  logic [TENSOR_WIDTH-1:0] frm_tensor_q, frm_tensor_d;
  fused_tx_meta_t          frm_meta_q, frm_meta_d;

`ifdef FUSED_TX_DOUBLE_BUFFER_EN
  logic [TENSOR_WIDTH-1:0] pnd_tensor_q, pnd_tensor_d;
  fused_tx_meta_t          pnd_meta_q, pnd_meta_d;
  logic                    pnd_vld_q, pnd_vld_d;

  always_comb begin
    in_ready     = !pnd_vld_q;
    // The frame register reloads when idle, or at the trailer handshake if
    // there is something to send next (pending entry first, else a tensor
    // accepted on this very edge).
    start        = (idle && in_valid) || (trl_hs && (pnd_vld_q || in_valid));
    frm_tensor_d = frm_tensor_q;
    frm_meta_d   = frm_meta_q;
    pnd_tensor_d = pnd_tensor_q;
    pnd_meta_d   = pnd_meta_q;
    pnd_vld_d    = pnd_vld_q;
    if (start) begin
      if (pnd_vld_q) begin
        frm_tensor_d = pnd_tensor_q;
        frm_meta_d   = pnd_meta_q;
        pnd_vld_d    = 1'b0;
      end else begin
        frm_tensor_d = in_tensor;
        frm_meta_d   = in_meta;
      end
    end else if (in_valid && in_ready) begin
      // frame in flight: park the tensor until its trailer goes out
      pnd_tensor_d = in_tensor;
      pnd_meta_d   = in_meta;
      pnd_vld_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pnd_tensor_q <= '0;
      pnd_meta_q   <= '0;
      pnd_vld_q    <= 1'b0;
    end else begin
      pnd_tensor_q <= pnd_tensor_d;
      pnd_meta_q   <= pnd_meta_d;
      pnd_vld_q    <= pnd_vld_d;
    end
  end
`else
  always_comb begin
    in_ready     = idle;
    start        = idle && in_valid;
    frm_tensor_d = start ? in_tensor : frm_tensor_q;
    frm_meta_d   = start ? in_meta   : frm_meta_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_tensor_q <= '0;
      frm_meta_q   <= '0;
    end else begin
      frm_tensor_q <= frm_tensor_d;
      frm_meta_q   <= frm_meta_d;
    end
  end

  assign frm_tensor = frm_tensor_q;
  assign frm_meta   = frm_meta_q;

endmodule

// File: rtl/fused_tensor_tx.sv
// fused_tensor_tx: serialises one fused tensor (+flags, timestamp) into a
// framed word stream: HDR {sync, seq, flags}, TS_HI, TS_LO, payload words
// (LSB word first), trailer = XOR of all preceding words of the frame.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fused_tensor_tx_if.slave (tensor in, word stream out, frame_seq)
// Optional build macro FUSED_TX_DOUBLE_BUFFER_EN adds a pending entry so the
// next frame's header follows the trailer with no idle cycle.
// Header/timestamp layout assumes WORD_WIDTH = 32.
module fused_tensor_tx
  import fused_tx_pkg::*;
#(
  parameter int          TENSOR_WIDTH = TENSOR_WIDTH_DEFAULT,
  parameter int          WORD_WIDTH   = WORD_WIDTH_DEFAULT,
  parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  fused_tensor_tx_if.slave bus
);

  localparam int             NWORDS   = TENSOR_WIDTH / WORD_WIDTH;
  localparam int             CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

  fused_tx_state_t         st_q, st_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   chk_q, chk_d;
  logic [7:0]              seq_q, seq_d;

  logic [TENSOR_WIDTH-1:0]            frm_tensor;
  logic [NWORDS-1:0][WORD_WIDTH-1:0]  pwords;
  fused_tx_meta_t                     frm_meta, in_meta;
  logic                               idle, start, hs, trl_hs, in_ready;
  logic [WORD_WIDTH-1:0]              tx_data;
  logic                               tx_valid, tx_sof, tx_last;

  assign in_meta = '{flags: bus.in_error_flags, ts: bus.in_timestamp};
  assign idle    = (st_q == ST_IDLE);
  assign pwords  = frm_tensor;

  fused_tx_holding_buf #(.TENSOR_WIDTH(TENSOR_WIDTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .in_tensor  (bus.in_tensor),
    .in_meta    (in_meta),
    .in_valid   (bus.in_valid),
    .in_ready   (in_ready),
    .idle       (idle),
`ifdef FUSED_TX_DOUBLE_BUFFER_EN
    .trl_hs     (trl_hs),
`endif
    .start      (start),
    .frm_tensor (frm_tensor),
    .frm_meta   (frm_meta)
  );

  // Stream outputs decode straight from state; everything they depend on
  // only changes at a handshake, so the word holds while tx_ready is low.
  always_comb begin
    tx_valid = !idle;
    tx_data  = '0;
    tx_sof   = 1'b0;
    tx_last  = 1'b0;
    case (st_q)
      ST_HDR: begin
        tx_data = WORD_WIDTH'({SYNC_WORD, seq_q, frm_meta.flags});
        tx_sof  = 1'b1;
      end
      ST_TS_HI:   tx_data = WORD_WIDTH'(frm_meta.ts[63:32]);
      ST_TS_LO:   tx_data = WORD_WIDTH'(frm_meta.ts[31:0]);
      ST_PAYLOAD: tx_data = pwords[cnt_q];
      ST_TRAILER: begin
        tx_data = chk_q;
        tx_last = 1'b1;
      end
      default: ;
    endcase
    hs     = tx_valid && bus.tx_ready;
    trl_hs = hs && (st_q == ST_TRAILER);
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    chk_d = hs ? (chk_q ^ tx_data) : chk_q;
    seq_d = seq_q;
    case (st_q)
      ST_IDLE: if (start) begin
        st_d  = ST_HDR;
        chk_d = '0;
      end
      ST_HDR:   if (hs) st_d = ST_TS_HI;
      ST_TS_HI: if (hs) st_d = ST_TS_LO;
      ST_TS_LO: if (hs) begin
        st_d  = ST_PAYLOAD;
        cnt_d = '0;
      end
      ST_PAYLOAD: if (hs) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) st_d = ST_TRAILER;
      end
      ST_TRAILER: if (trl_hs) begin
        seq_d = seq_q + 8'd1;
        chk_d = '0;
        cnt_d = '0;
        st_d  = start ? ST_HDR : ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      chk_q <= '0;
      seq_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      chk_q <= chk_d;
      seq_q <= seq_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.tx_data   = tx_data;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_sof    = tx_sof;
  assign bus.tx_last   = tx_last;
  assign bus.frame_seq = seq_q;

endmodule
